// File: rtl/oram_access_ctrl.sv
// Sequencer for one tree-ORAM access: position-map lookup, path read with
// match-and-invalidate, root insertion of the remapped block, then one top-down flush.
module oram_access_ctrl #(
    parameter int A = 8,
    parameter int D = 6,
    parameter int K = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [D-1:0]               req_bnum,
    input  logic [8*A-1:0]             req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [8*A-1:0]             rsp_data,
    output logic                       rsp_found,
    output logic                       overflow,
    input  logic [D-2:0]               rnd_leaf,
    output logic [D-1:0]               bkt_addr,
    output logic                       bkt_rd_en,
    input  logic [K*(2*D+8*A)-1:0]     bkt_rdata,
    output logic                       bkt_wr_en,
    output logic [K*(2*D+8*A)-1:0]     bkt_wdata,
    output logic [D-1:0]               pm_addr,
    output logic                       pm_rd_en,
    input  logic [D-1:0]               pm_rdata,
    output logic                       pm_wr_en,
    output logic [D-1:0]               pm_wdata
);
    localparam int VW = 8 * A;
    localparam int PW = D - 1;
    localparam int TW = 1 + PW + D + VW;
    localparam int BW = K * TW;
    localparam int LW = $clog2(D);
    localparam logic [D-1:0] ONE_D = D'(1);

    typedef enum logic [3:0] {
        IDLE, PM_RD, PM_WAIT, PATH_RD, PATH_CHK, ROOT_RD, ROOT_WR,
        FLUSH, FL_RD_HI, FL_RD_LO, FL_WR_LO, FL_WR_HI, DONE
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              op_r;
    logic [D-1:0]      bnum_r;
    logic [VW-1:0]     wdata_r;
    logic [PW-1:0]     pos_r;
    logic [PW-1:0]     fpos_r;
    logic              mapped_r;
    logic              found_r;
    logic [VW-1:0]     val_r;
    logic [LW-1:0]     level_r;
    logic [D-1:0]      node_r;
    logic [BW-1:0]     hi_r;
    logic              overflow_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              rsp_found_r;
    logic [VW-1:0]     rsp_data_r;

    logic              chk_hit_s;
    logic [VW-1:0]     chk_val_s;
    logic [BW-1:0]     chk_wdata_s;
    logic              ins_ok_s;
    logic [BW-1:0]     ins_wdata_s;
    logic [BW-1:0]     mv_hi_s;
    logic [BW-1:0]     mv_lo_s;
    logic              path_bit_s;
    logic              flush_bit_s;
    logic [D-1:0]      path_child_s;
    logic [D-1:0]      lo_node_s;
    logic [TW-1:0]     new_tuple_s;

    logic [D-1:0]      bkt_addr_s;
    logic              bkt_rd_en_s;
    logic              bkt_wr_en_s;
    logic [BW-1:0]     bkt_wdata_s;
    logic [D-1:0]      pm_addr_s;
    logic              pm_rd_en_s;
    logic              pm_wr_en_s;
    logic [D-1:0]      pm_wdata_s;

    function automatic logic [PW-1:0] tup_pos(input logic [TW-1:0] t);
        return t[TW-2 -: PW];
    endfunction

    // Lowest valid slot holding bnum is taken and invalidated; ignored when unmapped.
    function automatic logic [1+VW+BW-1:0] path_check(input logic [BW-1:0] bkt,
                                                      input logic [D-1:0] bnum,
                                                      input logic mapped);
        logic          hit;
        logic [VW-1:0] val;
        logic [BW-1:0] w;
        logic [TW-1:0] t;
        hit = 1'b0;
        val = {VW{1'b0}};
        w   = bkt;
        for (int k = 0; k < K; k++) begin
            t = bkt[k*TW +: TW];
            if (!hit && mapped && t[TW-1] && (t[VW +: D] == bnum)) begin
                hit = 1'b1;
                val = t[VW-1:0];
                w[k*TW + TW - 1] = 1'b0;
            end else begin
                hit = hit;
            end
        end
        return {hit, val, w};
    endfunction

    function automatic logic [BW:0] root_insert(input logic [BW-1:0] bkt,
                                                input logic [TW-1:0] tup);
        logic          ok;
        logic [BW-1:0] w;
        ok = 1'b0;
        w  = bkt;
        for (int k = 0; k < K; k++) begin
            if (!ok && !bkt[k*TW + TW - 1]) begin
                ok = 1'b1;
                w[k*TW +: TW] = tup;
            end else begin
                ok = ok;
            end
        end
        return {ok, w};
    endfunction

    // HI tuples whose leaf bit at this level follows the flush path drop into the
    // lowest free LO slot, in ascending HI slot order, until LO has no room left.
    function automatic logic [2*BW-1:0] flush_move(input logic [BW-1:0] hi,
                                                   input logic [BW-1:0] lo,
                                                   input logic [LW-1:0] lvl,
                                                   input logic want);
        logic [BW-1:0] h;
        logic [BW-1:0] w;
        logic [TW-1:0] t;
        logic [PW-1:0] p;
        logic          placed;
        h = hi;
        w = lo;
        for (int i = 0; i < K; i++) begin
            t = h[i*TW +: TW];
            p = tup_pos(t);
            placed = 1'b0;
            if (t[TW-1] && (p[lvl] == want)) begin
                for (int j = 0; j < K; j++) begin
                    if (!placed && !w[j*TW + TW - 1]) begin
                        w[j*TW +: TW] = t;
                        placed = 1'b1;
                    end else begin
                        placed = placed;
                    end
                end
                if (placed) begin
                    h[i*TW + TW - 1] = 1'b0;
                end else begin
                    h = h;
                end
            end else begin
                placed = 1'b0;
            end
        end
        return {h, w};
    endfunction

    assign path_bit_s   = (level_r < LW'(PW)) ? pos_r[level_r] : 1'b0;
    assign flush_bit_s  = (level_r < LW'(PW)) ? fpos_r[level_r] : 1'b0;
    assign path_child_s = {node_r[D-2:0], path_bit_s};
    assign lo_node_s    = {node_r[D-2:0], flush_bit_s};
    assign new_tuple_s  = {1'b1, rnd_leaf, bnum_r, (op_r ? wdata_r : val_r)};

    assign {chk_hit_s, chk_val_s, chk_wdata_s} = path_check(bkt_rdata, bnum_r, mapped_r);
    assign {ins_ok_s, ins_wdata_s}             = root_insert(bkt_rdata, new_tuple_s);
    assign {mv_hi_s, mv_lo_s}                  = flush_move(hi_r, bkt_rdata, level_r, flush_bit_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: fixed walk, only DONE waits on the requester
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:     state_next_s = req_valid ? PM_RD : IDLE;
            PM_RD:    state_next_s = PM_WAIT;
            PM_WAIT:  state_next_s = PATH_RD;
            PATH_RD:  state_next_s = PATH_CHK;
            PATH_CHK: state_next_s = (level_r == LW'(D - 1)) ? ROOT_RD : PATH_RD;
            ROOT_RD:  state_next_s = ROOT_WR;
            ROOT_WR:  state_next_s = FLUSH;
            FLUSH:    state_next_s = FL_RD_HI;
            FL_RD_HI: state_next_s = FL_RD_LO;
            FL_RD_LO: state_next_s = FL_WR_LO;
            FL_WR_LO: state_next_s = FL_WR_HI;
            FL_WR_HI: state_next_s = (level_r == LW'(D - 2)) ? DONE : FL_RD_HI;
            DONE:     state_next_s = rsp_ready ? IDLE : DONE;
            default:  state_next_s = IDLE;
        endcase
    end

    // RAM command decode for the current state
    always_comb begin
        bkt_addr_s  = {D{1'b0}};
        bkt_rd_en_s = 1'b0;
        bkt_wr_en_s = 1'b0;
        bkt_wdata_s = {BW{1'b0}};
        pm_addr_s   = {D{1'b0}};
        pm_rd_en_s  = 1'b0;
        pm_wr_en_s  = 1'b0;
        pm_wdata_s  = {D{1'b0}};
        case (state_r)
            PM_RD: begin
                pm_addr_s  = bnum_r;
                pm_rd_en_s = 1'b1;
            end
            PATH_RD: begin
                bkt_addr_s  = node_r - ONE_D;
                bkt_rd_en_s = 1'b1;
            end
            PATH_CHK: begin
                bkt_addr_s  = node_r - ONE_D;
                bkt_wr_en_s = chk_hit_s;
                bkt_wdata_s = chk_hit_s ? chk_wdata_s : {BW{1'b0}};
            end
            ROOT_RD: begin
                bkt_rd_en_s = 1'b1;
            end
            ROOT_WR: begin
                bkt_wr_en_s = ins_ok_s;
                bkt_wdata_s = ins_ok_s ? ins_wdata_s : {BW{1'b0}};
                pm_addr_s   = bnum_r;
                pm_wr_en_s  = 1'b1;
                pm_wdata_s  = ins_ok_s ? {1'b1, rnd_leaf} : {D{1'b0}};
            end
            FL_RD_HI: begin
                bkt_addr_s  = node_r - ONE_D;
                bkt_rd_en_s = 1'b1;
            end
            FL_RD_LO: begin
                bkt_addr_s  = lo_node_s - ONE_D;
                bkt_rd_en_s = 1'b1;
            end
            FL_WR_LO: begin
                bkt_addr_s  = lo_node_s - ONE_D;
                bkt_wr_en_s = 1'b1;
                bkt_wdata_s = mv_lo_s;
            end
            FL_WR_HI: begin
                bkt_addr_s  = node_r - ONE_D;
                bkt_wr_en_s = 1'b1;
                bkt_wdata_s = hi_r;
            end
            default: begin
                bkt_rd_en_s = 1'b0;
            end
        endcase
    end

    // Access context, flush cursor and registered response/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= 1'b0;
            bnum_r      <= {D{1'b0}};
            wdata_r     <= {VW{1'b0}};
            pos_r       <= {PW{1'b0}};
            fpos_r      <= {PW{1'b0}};
            mapped_r    <= 1'b0;
            found_r     <= 1'b0;
            val_r       <= {VW{1'b0}};
            level_r     <= {LW{1'b0}};
            node_r      <= ONE_D;
            hi_r        <= {BW{1'b0}};
            overflow_r  <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_found_r <= 1'b0;
            rsp_data_r  <= {VW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r    <= req_op;
                        bnum_r  <= req_bnum;
                        wdata_r <= req_wdata;
                        found_r <= 1'b0;
                        val_r   <= {VW{1'b0}};
                    end else begin
                        op_r <= op_r;
                    end
                end
                PM_WAIT: begin
                    pos_r    <= pm_rdata[PW] ? pm_rdata[PW-1:0] : rnd_leaf;
                    mapped_r <= pm_rdata[PW];
                    level_r  <= {LW{1'b0}};
                    node_r   <= ONE_D;
                end
                PATH_CHK: begin
                    if (chk_hit_s) begin
                        found_r <= 1'b1;
                        val_r   <= chk_val_s;
                    end else begin
                        found_r <= found_r;
                    end
                    if (level_r != LW'(D - 1)) begin
                        level_r <= level_r + LW'(1);
                        node_r  <= path_child_s;
                    end else begin
                        level_r <= level_r;
                    end
                end
                ROOT_WR: begin
                    overflow_r <= overflow_r | ~ins_ok_s;
                end
                FLUSH: begin
                    fpos_r  <= rnd_leaf;
                    level_r <= {LW{1'b0}};
                    node_r  <= ONE_D;
                end
                FL_RD_LO: hi_r <= bkt_rdata;
                FL_WR_LO: hi_r <= mv_hi_s;
                FL_WR_HI: begin
                    if (level_r != LW'(D - 2)) begin
                        level_r <= level_r + LW'(1);
                        node_r  <= lo_node_s;
                    end else begin
                        level_r <= level_r;
                    end
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == DONE);
            rsp_found_r <= (state_next_s == DONE) ? found_r : 1'b0;
            rsp_data_r  <= (state_next_s == DONE) ? val_r : {VW{1'b0}};
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_found = rsp_found_r;
    assign rsp_data  = rsp_data_r;
    assign overflow  = overflow_r;

    // A reset cycle must never let a pending RAM command through
    assign bkt_addr  = bkt_addr_s;
    assign bkt_rd_en = bkt_rd_en_s & ~rst;
    assign bkt_wr_en = bkt_wr_en_s & ~rst;
    assign bkt_wdata = bkt_wdata_s;
    assign pm_addr   = pm_addr_s;
    assign pm_rd_en  = pm_rd_en_s & ~rst;
    assign pm_wr_en  = pm_wr_en_s & ~rst;
    assign pm_wdata  = pm_wdata_s;

endmodule

// File: tb/tb_oram_access_ctrl.sv
// Bench for oram_access_ctrl: behavioural bucket/pos-map RAMs plus a response
// scoreboard, exercised by one task per scenario.
module tb_oram_access_ctrl;
    localparam int A  = 8;
    localparam int D  = 6;
    localparam int K  = 3;
    localparam int VW = 8 * A;
    localparam int PW = D - 1;
    localparam int TW = 1 + PW + D + VW;
    localparam int BW = K * TW;
    localparam int LAT = 6 * D + 1;

    typedef struct {
        logic [VW-1:0] data;
        logic          found;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_op;
    logic [D-1:0]  req_bnum;
    logic [VW-1:0] req_wdata;
    logic rsp_valid, rsp_ready, rsp_found, overflow;
    logic [VW-1:0] rsp_data;
    logic [PW-1:0] rnd_leaf;
    logic [D-1:0]  bkt_addr, pm_addr, pm_rdata, pm_wdata;
    logic bkt_rd_en, bkt_wr_en, pm_rd_en, pm_wr_en;
    logic [BW-1:0] bkt_rdata, bkt_wdata;

    logic [BW-1:0] bkt_mem [0:63];
    logic [D-1:0]  pm_mem  [0:63];
    logic          clr_mem, pre_bkt_we, pre_pm_we;
    logic [D-1:0]  pre_addr;
    logic [BW-1:0] pre_bkt_data;
    logic [D-1:0]  pre_pm_data;
    int            wr_cnt = 0;
    int            conflict_cnt = 0;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    oram_access_ctrl #(.A(A), .D(D), .K(K)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_bnum(req_bnum), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_found(rsp_found), .overflow(overflow), .rnd_leaf(rnd_leaf),
        .bkt_addr(bkt_addr), .bkt_rd_en(bkt_rd_en), .bkt_rdata(bkt_rdata),
        .bkt_wr_en(bkt_wr_en), .bkt_wdata(bkt_wdata),
        .pm_addr(pm_addr), .pm_rd_en(pm_rd_en), .pm_rdata(pm_rdata),
        .pm_wr_en(pm_wr_en), .pm_wdata(pm_wdata)
    );

    // Single-port RAM models with one-cycle read latency, plus bench preload port
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) begin
                bkt_mem[i] <= {BW{1'b0}};
                pm_mem[i]  <= {D{1'b0}};
            end
        end else if (pre_bkt_we) begin
            bkt_mem[pre_addr] <= pre_bkt_data;
        end else if (pre_pm_we) begin
            pm_mem[pre_addr] <= pre_pm_data;
        end else begin
            if (bkt_wr_en) bkt_mem[bkt_addr] <= bkt_wdata;
            if (pm_wr_en)  pm_mem[pm_addr]   <= pm_wdata;
        end
        if (bkt_rd_en) bkt_rdata <= bkt_mem[bkt_addr];
        if (pm_rd_en)  pm_rdata  <= pm_mem[pm_addr];
        if (bkt_wr_en || pm_wr_en) wr_cnt <= wr_cnt + 1;
    end

    always @(negedge clk) begin
        if (bkt_rd_en === 1'b1 && bkt_wr_en === 1'b1) conflict_cnt <= conflict_cnt + 1;
    end

    function automatic logic [TW-1:0] mk_tup(input logic [PW-1:0] pos, input logic [D-1:0] b,
                                            input logic [VW-1:0] v);
        return {1'b1, pos, b, v};
    endfunction

    function automatic int count_copies(input logic [D-1:0] b);
        int n;
        logic [BW-1:0] w;
        logic [TW-1:0] t;
        n = 0;
        for (int a = 0; a < 63; a++) begin
            w = bkt_mem[a];
            for (int k = 0; k < K; k++) begin
                t = w[k*TW +: TW];
                if (t[TW-1] && t[VW +: D] == b) n++;
            end
        end
        return n;
    endfunction

    task automatic clear_mems();
        @(negedge clk); clr_mem = 1'b1;
        @(negedge clk); clr_mem = 1'b0;
    endtask

    task automatic pre_bkt(input logic [D-1:0] a, input logic [BW-1:0] d);
        @(negedge clk); pre_bkt_we = 1'b1; pre_addr = a; pre_bkt_data = d;
        @(negedge clk); pre_bkt_we = 1'b0;
    endtask

    task automatic pre_pm(input logic [D-1:0] a, input logic [D-1:0] d);
        @(negedge clk); pre_pm_we = 1'b1; pre_addr = a; pre_pm_data = d;
        @(negedge clk); pre_pm_we = 1'b0;
    endtask

    // One access: drives the request, pops the scoreboard on the response, checks timing
    task automatic do_access(input logic op, input logic [D-1:0] bnum, input logic [VW-1:0] wdata,
                             input int hold, input logic leaf_fix,
                             output int lat, output logic [PW-1:0] root_leaf);
        int   c;
        bit   seen;
        exp_t e;
        lat = -1; root_leaf = {PW{1'b0}}; seen = 1'b0; c = 0;
        e.data = {VW{1'b0}}; e.found = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_op = op; req_bnum = bnum; req_wdata = wdata;
        @(posedge clk);
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                lat = c - 1;
            end else begin
                rnd_leaf = leaf_fix ? {PW{1'b0}} : PW'($urandom);
                if (c == 16) root_leaf = rnd_leaf;
            end
        end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL latency bnum=%0d: got %0d want %0d", bnum, lat, LAT); end
        if (seen) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL scoreboard_empty: got response with no expectation");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (rsp_data !== e.data) begin n_fail++; $display("FAIL rsp_data bnum=%0d: got %h want %h", bnum, rsp_data, e.data); end
                n_checks++;
                if (rsp_found !== e.found) begin n_fail++; $display("FAIL rsp_found bnum=%0d: got %b want %b", bnum, rsp_found, e.found); end
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold cycle %0d: valid=%b data=%h ready=%b want 1 %h 0", h, rsp_valid, rsp_data, req_ready, e.data);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++; $display("FAIL release: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_mems();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({rsp_valid, rsp_found, overflow, bkt_rd_en, bkt_wr_en, pm_rd_en, pm_wr_en} !== 7'b0 || rsp_data !== {VW{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b data=%h want 0", {rsp_valid, rsp_found, overflow, bkt_rd_en, bkt_wr_en, pm_rd_en, pm_wr_en}, rsp_data);
        end
    endtask

    task automatic test_write_fresh();
        int lat;
        logic [PW-1:0] rl;
        sb.push_back('{data: {VW{1'b0}}, found: 1'b0});
        do_access(1'b1, 6'd5, 64'h1122334455667788, 0, 1'b0, lat, rl);
        n_checks++;
        if (pm_mem[5] !== {1'b1, rl}) begin n_fail++; $display("FAIL write_pm: got %b want %b", pm_mem[5], {1'b1, rl}); end
        n_checks++;
        if (count_copies(6'd5) != 1) begin n_fail++; $display("FAIL write_copies: got %0d want 1", count_copies(6'd5)); end
    endtask

    task automatic test_read_back();
        int lat;
        logic [PW-1:0] rl;
        sb.push_back('{data: 64'h1122334455667788, found: 1'b1});
        do_access(1'b0, 6'd5, {VW{1'b0}}, 0, 1'b0, lat, rl);
        n_checks++;
        if (count_copies(6'd5) != 1) begin n_fail++; $display("FAIL read_copies: got %0d want 1", count_copies(6'd5)); end
        n_checks++;
        if (pm_mem[5] !== {1'b1, rl}) begin n_fail++; $display("FAIL read_pm: got %b want %b", pm_mem[5], {1'b1, rl}); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [PW-1:0] rl;
        logic [BW-1:0] root;
        root = {mk_tup(5'b00011, 6'd12, 64'hCCCC), mk_tup(5'b00101, 6'd11, 64'hBBBB), mk_tup(5'b00001, 6'd10, 64'hAAAA)};
        clear_mems();
        pre_bkt(6'd0, root);
        pre_pm(6'd20, 6'b010101);
        sb.push_back('{data: {VW{1'b0}}, found: 1'b0});
        do_access(1'b0, 6'd20, {VW{1'b0}}, 0, 1'b1, lat, rl);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", overflow); end
        n_checks++;
        if (bkt_mem[0] !== root) begin n_fail++; $display("FAIL overflow_root: got %h want %h", bkt_mem[0], root); end
        n_checks++;
        if (pm_mem[20] !== 6'b000000) begin n_fail++; $display("FAIL overflow_pm: got %b want 000000", pm_mem[20]); end
    endtask

    task automatic test_flush();
        int lat;
        logic [PW-1:0] rl;
        logic [TW-1:0] ta, tb, t;
        ta = mk_tup(5'b00000, 6'd7, 64'hA5A5A5A5A5A5A5A5);
        tb = mk_tup(5'b00001, 6'd8, 64'h5A5A5A5A5A5A5A5A);
        clear_mems();
        pre_bkt(6'd0, {{TW{1'b0}}, tb, ta});
        pre_pm(6'd7, 6'b100000);
        pre_pm(6'd8, 6'b100001);
        sb.push_back('{data: {VW{1'b0}}, found: 1'b0});
        do_access(1'b0, 6'd9, {VW{1'b0}}, 0, 1'b1, lat, rl);
        t = bkt_mem[31][0 +: TW];
        n_checks++;
        if (t !== ta) begin n_fail++; $display("FAIL flush_leaf32: got %h want %h", t, ta); end
        t = bkt_mem[31][TW +: TW];
        n_checks++;
        if (t[TW-1] !== 1'b1 || t[VW +: D] !== 6'd9) begin n_fail++; $display("FAIL flush_leaf32_slot1: got v=%b b=%0d want v=1 b=9", t[TW-1], t[VW +: D]); end
        t = bkt_mem[0][TW +: TW];
        n_checks++;
        if (t !== tb || bkt_mem[0][TW-1] !== 1'b0) begin n_fail++; $display("FAIL flush_root: got %h want slot1 %h, slot0 empty", bkt_mem[0], tb); end
        n_checks++;
        if (bkt_mem[1][BW-1:0] !== {BW{1'b0}} && (bkt_mem[1][TW-1] | bkt_mem[1][2*TW-1] | bkt_mem[1][3*TW-1]) !== 1'b0) begin
            n_fail++; $display("FAIL flush_node2: got %h want no valid tuples", bkt_mem[1]);
        end
        n_checks++;
        if (count_copies(6'd7) != 1) begin n_fail++; $display("FAIL flush_copies: got %0d want 1", count_copies(6'd7)); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [PW-1:0] rl;
        sb.push_back('{data: {VW{1'b0}}, found: 1'b0});
        do_access(1'b1, 6'd3, 64'hDEADBEEF01234567, 0, 1'b0, lat, rl);
        sb.push_back('{data: 64'hDEADBEEF01234567, found: 1'b1});
        do_access(1'b0, 6'd3, {VW{1'b0}}, 10, 1'b0, lat, rl);
    endtask

    task automatic test_reset_mid();
        int snap;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b1; req_bnum = 6'd2; req_wdata = 64'h0F0F;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            rnd_leaf = PW'($urandom);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap = wr_cnt;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({rsp_valid, rsp_found, overflow, bkt_rd_en, bkt_wr_en, pm_rd_en, pm_wr_en} !== 7'b0 || bkt_addr !== 6'd0 || bkt_wdata !== {BW{1'b0}}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b addr=%0d want 0", {rsp_valid, rsp_found, overflow, bkt_rd_en, bkt_wr_en, pm_rd_en, pm_wr_en}, bkt_addr);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_cnt != snap) begin n_fail++; $display("FAIL midreset_writes: got %0d writes want 0", wr_cnt - snap); end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_idle: valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_bnum = {D{1'b0}}; req_wdata = {VW{1'b0}};
        rsp_ready = 1'b0; rnd_leaf = {PW{1'b0}};
        clr_mem = 1'b0; pre_bkt_we = 1'b0; pre_pm_we = 1'b0; pre_addr = {D{1'b0}};
        pre_bkt_data = {BW{1'b0}}; pre_pm_data = {D{1'b0}};
        test_reset();
        test_write_fresh();
        test_read_back();
        test_overflow();
        test_flush();
        test_back_pressure();
        test_reset_mid();
        n_checks++;
        if (conflict_cnt != 0) begin n_fail++; $display("FAIL rd_wr_conflict: got %0d cycles want 0", conflict_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oram_access_ctrl.md
Name: oram_access_ctrl

Overview:
- Sequencing controller for one tree-ORAM access: position-map lookup, path read with match-and-invalidate, remap to a fresh random leaf, root insertion, then a single top-down flush along a random leaf path.
- Drives external single-port bucket RAM and position-map RAM, one access at a time.
- Sits between the client request port and the ORAM storage; random leaves come from an external LFSR.

Parameters:
A, 8, bytes per block value
D, 6, tree depth in levels; block number width D bits, leaf width D-1 bits, tree holds 2^D-1 nodes
K, 3, tuples per bucket (all K slots are used)
TW, derived 1+(D-1)+D+8*A, tuple width packed {valid, pos, bnum, val}, valid at MSB
BW, derived K*TW, bucket width, slot 0 in the LSBs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  access request
req_ready  out  1  high only in IDLE
req_op  in  1  0=read, 1=write
req_bnum  in  D  block number
req_wdata  in  8*A  write value
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  8*A  block value before this access (0 if not found)
rsp_found  out  1  block was present in the path
overflow  out  1  sticky: a root insertion found no empty slot
rnd_leaf  in  D-1  random leaf, sampled when needed
bkt_addr  out  D  node address (node number minus 1)
bkt_rd_en  out  1  bucket read; data arrives next cycle
bkt_rdata  in  BW  bucket read data
bkt_wr_en  out  1  bucket write
bkt_wdata  out  BW  bucket write data
pm_addr  out  D  position-map address (block number)
pm_rd_en  out  1  position-map read; 1-cycle latency
pm_rdata  in  D  {valid, pos}
pm_wr_en  out  1  position-map write
pm_wdata  out  D  {valid, pos}

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - req_ready=1 out of reset. All other outputs are 0, including overflow.
  - RAM contents are untouched.
  - Reset mid-access aborts immediately; no further RAM writes are issued.
- Node numbering: root is node 1. The child at level l is 2*node+pos[l-1]. Addresses are node-1.
- Acceptance: req_valid & req_ready in IDLE latches op, bnum and wdata.
- States, one cycle each unless noted:
  - PM_RD: read position map at bnum.
  - PM_WAIT: latch pos. If the entry is invalid, pos=rnd_leaf and found is forced 0.
  - PATH_RD/PATH_CHK x D levels, root first: CHK compares every slot for valid & bnum==req_bnum.
    - On match, the lowest matching slot is taken: val is captured, valid is cleared and the bucket is written back in the same cycle.
    - With no match, no write is issued.
    - If the pos-map entry was invalid, the path is still walked for obliviousness, but matches are ignored.
  - ROOT_RD, then ROOT_WR: the new tuple is written into the lowest empty root slot and pm is written with {1, new_pos}.
    - new_pos = rnd_leaf sampled in ROOT_WR.
    - new val = req_wdata if op=1, else the captured val (0 if not found).
    - No empty slot: no bucket write, pm is written {0,0}, overflow is set.
  - FLUSH: pos* = rnd_leaf, sampled on entry. For levels l=0..D-2, 4 states per level:
    - RD_HI, RD_LO, WR_LO, WR_HI.
    - Each valid HI tuple with pos[l]==pos*[l] moves, in ascending slot order, to the lowest empty LO slot. Its HI valid is cleared.
    - Stop moving when LO is full.
    - Both buckets are always written back.
  - DONE: rsp_valid=1 with rsp_data/rsp_found stable until rsp_ready, then return to IDLE. A new request can be accepted the following cycle.
- Latency: rsp_valid rises exactly 6*D+1 cycles after the accepting edge (37 for D=6), independent of data. Access pattern is data-independent except for write enables.
- Never assert bkt_rd_en and bkt_wr_en in the same cycle.
- req_valid outside IDLE is ignored; the requester must hold it.

Test Plan:
- Write bnum=5, wdata=0x1122334455667788, on a fresh zeroed tree -> rsp_found=0, rsp_data=0, rsp_valid exactly 37 cycles after accept, pm[5]={1,rnd_leaf at ROOT_WR}.
- Read bnum=5 after that -> rsp_found=1, rsp_data=0x1122334455667788, exactly one valid copy of bnum 5 remains in the tree.
- Preload root with 3 valid tuples, then read an unmapped bnum -> overflow=1 (sticky), no root write, pm[bnum]={0,0}, response still at cycle 37.
- Flush with rnd_leaf=0: root tuple pos=0 is pushed to node 2 and down to leaf node 32; a tuple with pos bit0=1 stays in the root.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data held, req_ready=0; release -> IDLE next cycle.
- Assert rst at cycle 12 of an access -> next cycle all outputs 0, req_ready=1, no bkt_wr_en/pm_wr_en afterwards.
